// File: rtl/lsu_if.sv
// Handshake bundle between the execute stage, the LSU, memory and writeback.
// master = the LSU itself, slave = the surrounding pipeline and memory.
interface lsu_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [AWIDTH-1:0] in_addr;
  logic [DWIDTH-1:0] in_wdata;
  logic              in_wen;
  logic [1:0]        in_size;
  logic              in_unsigned;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [AWIDTH-1:0] mem_req_addr;
  logic              mem_req_wen;
  logic [DWIDTH-1:0] mem_req_wdata;
  logic [3:0]        mem_req_wstrb;

  logic              mem_resp_valid;
  logic              mem_resp_ready;
  logic [DWIDTH-1:0] mem_resp_rdata;

  logic              out_valid;
  logic              out_ready;
  logic [DWIDTH-1:0] out_rdata;
  logic              out_err;

  modport master (
    input  in_valid, in_addr, in_wdata, in_wen, in_size, in_unsigned,
    output in_ready,
    output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb,
    input  mem_req_ready,
    input  mem_resp_valid, mem_resp_rdata,
    output mem_resp_ready,
    output out_valid, out_rdata, out_err,
    input  out_ready
  );

  modport slave (
    output in_valid, in_addr, in_wdata, in_wen, in_size, in_unsigned,
    input  in_ready,
    input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb,
    output mem_req_ready,
    output mem_resp_valid, mem_resp_rdata,
    input  mem_resp_ready,
    input  out_valid, out_rdata, out_err,
    output out_ready
  );
endinterface

// File: rtl/lsu.sv
// Multi-cycle load/store unit: one memory transaction per op, misaligned ops
// are flagged and short-circuit straight to the writeback handshake.
module lsu #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32
) (
  input  logic  clock,
  input  logic  reset,
  lsu_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        off_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic              wen_q;
  logic [AWIDTH-1:0] req_addr_q;
  logic [DWIDTH-1:0] req_wdata_q;
  logic [3:0]        req_wstrb_q;
  logic [DWIDTH-1:0] rdata_q;
  logic              err_q;
  logic              accept_s;
  logic              mis_s;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    logic m;
    case (size)
      2'd0:    m = 1'b0;
      2'd1:    m = off[0];
      2'd2:    m = (off != 2'd0);
      default: m = 1'b1;
    endcase
    return m;
  endfunction

  function automatic logic [3:0] strobe(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] s;
    case (size)
      2'd0:    s = 4'b0001 << off;
      2'd1:    s = 4'b0011 << off;
      2'd2:    s = 4'b1111;
      default: s = 4'b0000;
    endcase
    return s;
  endfunction

  function automatic logic [DWIDTH-1:0] lane_data(input logic [1:0] size, input logic [DWIDTH-1:0] wd);
    logic [DWIDTH-1:0] d;
    case (size)
      2'd0:    d = {4{wd[7:0]}};
      2'd1:    d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

  function automatic logic [DWIDTH-1:0] extract(input logic [DWIDTH-1:0] rd, input logic [1:0] off,
                                                input logic [1:0] size, input logic uns);
    logic [DWIDTH-1:0] sh;
    logic [DWIDTH-1:0] r;
    sh = rd >> {off, 3'b000};
    case (size)
      2'd0:    r = {{(DWIDTH-8){~uns & sh[7]}}, sh[7:0]};
      2'd1:    r = {{(DWIDTH-16){~uns & sh[15]}}, sh[15:0]};
      default: r = sh;
    endcase
    return r;
  endfunction

  assign accept_s = (state_q == IDLE) && bus.in_valid;
  assign mis_s    = misaligned(bus.in_size, bus.in_addr[1:0]);

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = mis_s ? DONE : REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (bus.mem_req_ready) begin
          state_d = WAIT;
        end else begin
          state_d = REQ;
        end
      end
      WAIT: begin
        if (bus.mem_resp_valid) begin
          state_d = DONE;
        end else begin
          state_d = WAIT;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register
  always_comb begin
    bus.in_ready       = 1'b0;
    bus.mem_req_valid  = 1'b0;
    bus.mem_resp_ready = 1'b0;
    bus.out_valid      = 1'b0;
    case (state_q)
      IDLE:    bus.in_ready       = 1'b1;
      REQ:     bus.mem_req_valid  = 1'b1;
      WAIT:    bus.mem_resp_ready = 1'b1;
      DONE:    bus.out_valid      = 1'b1;
      default: bus.in_ready       = 1'b0;
    endcase
  end

  // Request fields are formatted once at accept so they stay stable under backpressure
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      off_q       <= 2'd0;
      size_q      <= 2'd0;
      uns_q       <= 1'b0;
      wen_q       <= 1'b0;
      req_addr_q  <= {AWIDTH{1'b0}};
      req_wdata_q <= {DWIDTH{1'b0}};
      req_wstrb_q <= 4'b0000;
      rdata_q     <= {DWIDTH{1'b0}};
      err_q       <= 1'b0;
    end else if (accept_s) begin
      off_q       <= bus.in_addr[1:0];
      size_q      <= bus.in_size;
      uns_q       <= bus.in_unsigned;
      wen_q       <= bus.in_wen;
      req_addr_q  <= {bus.in_addr[AWIDTH-1:2], 2'b00};
      req_wdata_q <= lane_data(bus.in_size, bus.in_wdata);
      req_wstrb_q <= bus.in_wen ? strobe(bus.in_size, bus.in_addr[1:0]) : 4'b0000;
      rdata_q     <= {DWIDTH{1'b0}};
      err_q       <= mis_s;
    end else if ((state_q == WAIT) && bus.mem_resp_valid) begin
      rdata_q <= wen_q ? {DWIDTH{1'b0}} : extract(bus.mem_resp_rdata, off_q, size_q, uns_q);
    end else if ((state_q == DONE) && bus.out_ready) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_q;
    end
  end

  assign bus.mem_req_addr  = req_addr_q;
  assign bus.mem_req_wen   = wen_q;
  assign bus.mem_req_wdata = req_wdata_q;
  assign bus.mem_req_wstrb = req_wstrb_q;
  assign bus.out_rdata     = rdata_q;
  assign bus.out_err       = err_q;

endmodule

// File: tb/tb_lsu.sv
// Randomized self-checking bench for lsu; expectations come from a byte-level
// reference model of loads/stores and fixed cycle positions of each handshake.
module tb_lsu;

  logic clock = 1'b0;
  logic reset;

  lsu_if bus ();

  lsu dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic model_mis(input logic [31:0] addr, input logic [1:0] size);
    if (size == 2'd3) return 1'b1;
    return (int'(addr[1:0]) % nbytes(size)) != 0;
  endfunction

  // Gather the accessed bytes little-endian, then sign-extend arithmetically
  function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [31:0] addr,
                                             input logic [1:0] size, input logic uns);
    int n = nbytes(size);
    int off = int'(addr[1:0]);
    longint v = 0;
    for (int i = 0; i < n; i++) begin
      v += longint'(rdata[8*(off+i) +: 8]) << (8*i);
    end
    if (!uns && n < 4 && v >= (longint'(1) << (8*n-1))) v -= (longint'(1) << (8*n));
    return v[31:0];
  endfunction

  function automatic logic [3:0] model_strb(input logic [31:0] addr, input logic [1:0] size);
    logic [3:0] s = 4'b0000;
    for (int i = 0; i < nbytes(size); i++) s[int'(addr[1:0]) + i] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] wd, input logic [1:0] size);
    logic [31:0] r;
    for (int lane = 0; lane < 4; lane++) r[8*lane +: 8] = wd[8*(lane % nbytes(size)) +: 8];
    return r;
  endfunction

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    check_eq({tag, "_req_valid"}, {31'd0, bus.mem_req_valid}, 32'd0);
    check_eq({tag, "_req_wen"}, {31'd0, bus.mem_req_wen}, 32'd0);
    check_eq({tag, "_resp_ready"}, {31'd0, bus.mem_resp_ready}, 32'd0);
    check_eq({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
    check_eq({tag, "_out_err"}, {31'd0, bus.out_err}, 32'd0);
    check_eq({tag, "_req_addr"}, bus.mem_req_addr, 32'd0);
    check_eq({tag, "_req_wdata"}, bus.mem_req_wdata, 32'd0);
    check_eq({tag, "_req_wstrb"}, {28'd0, bus.mem_req_wstrb}, 32'd0);
    check_eq({tag, "_out_rdata"}, bus.out_rdata, 32'd0);
  endtask

  task automatic check_req(input logic [31:0] addr, input logic [31:0] wdata, input logic wen,
                           input logic [1:0] size);
    check_eq("req_valid", {31'd0, bus.mem_req_valid}, 32'd1);
    check_eq("req_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check_eq("req_addr", bus.mem_req_addr, {addr[31:2], 2'b00});
    check_eq("req_wen", {31'd0, bus.mem_req_wen}, {31'd0, wen});
    check_eq("req_wstrb", {28'd0, bus.mem_req_wstrb}, {28'd0, wen ? model_strb(addr, size) : 4'b0000});
    if (wen) check_eq("req_wdata", bus.mem_req_wdata, model_wdata(wdata, size));
  endtask

  // One full op; inputs change at negedges, every check happens at a negedge
  task automatic run_op(input logic [31:0] addr, input logic [31:0] wdata, input logic wen,
                        input logic [1:0] size, input logic uns, input logic [31:0] rdata,
                        input int rq_dly, input int rs_dly, input int out_dly);
    logic        mis = model_mis(addr, size);
    logic [31:0] exp_out = (wen || mis) ? 32'd0 : model_load(rdata, addr, size, uns);

    check_eq("idle_in_ready", {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid    = 1'b1;
    bus.in_addr     = addr;
    bus.in_wdata    = wdata;
    bus.in_wen      = wen;
    bus.in_size     = size;
    bus.in_unsigned = uns;
    @(negedge clock);
    bus.in_valid    = 1'b0;
    bus.in_addr     = $urandom;
    bus.in_wdata    = $urandom;
    bus.in_wen      = 1'($urandom);
    bus.in_size     = 2'($urandom);
    check_eq("busy_in_ready", {31'd0, bus.in_ready}, 32'd0);

    if (mis) begin
      check_eq("mis_req_valid", {31'd0, bus.mem_req_valid}, 32'd0);
    end else begin
      for (int c = 0; c < rq_dly; c++) begin
        check_req(addr, wdata, wen, size);
        bus.mem_resp_valid = 1'($urandom);
        @(negedge clock);
        bus.mem_resp_valid = 1'b0;
      end
      check_req(addr, wdata, wen, size);
      bus.mem_req_ready = 1'b1;
      @(negedge clock);
      bus.mem_req_ready = 1'b0;
      check_eq("wait_req_valid", {31'd0, bus.mem_req_valid}, 32'd0);
      for (int c = 0; c < rs_dly; c++) begin
        check_eq("wait_resp_ready", {31'd0, bus.mem_resp_ready}, 32'd1);
        check_eq("wait_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check_eq("wait_in_ready", {31'd0, bus.in_ready}, 32'd0);
        bus.mem_req_ready  = 1'($urandom);
        bus.mem_resp_rdata = $urandom;
        @(negedge clock);
        bus.mem_req_ready  = 1'b0;
      end
      check_eq("wait_resp_ready", {31'd0, bus.mem_resp_ready}, 32'd1);
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_rdata = rdata;
      @(negedge clock);
      bus.mem_resp_valid = 1'b0;
      bus.mem_resp_rdata = $urandom;
    end

    for (int c = 0; c <= out_dly; c++) begin
      check_eq("done_out_valid", {31'd0, bus.out_valid}, 32'd1);
      check_eq("done_out_rdata", bus.out_rdata, exp_out);
      check_eq("done_out_err", {31'd0, bus.out_err}, {31'd0, mis});
      check_eq("done_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check_eq("done_req_valid", {31'd0, bus.mem_req_valid}, 32'd0);
      check_eq("done_resp_ready", {31'd0, bus.mem_resp_ready}, 32'd0);
      if (c < out_dly) begin
        bus.mem_resp_valid = 1'($urandom);
        bus.mem_req_ready  = 1'($urandom);
        @(negedge clock);
        bus.mem_resp_valid = 1'b0;
        bus.mem_req_ready  = 1'b0;
      end
    end
    bus.out_ready = 1'b1;
    @(negedge clock);
    bus.out_ready = 1'b0;
    check_eq("after_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check_eq("after_out_err", {31'd0, bus.out_err}, 32'd0);
    check_eq("after_in_ready", {31'd0, bus.in_ready}, 32'd1);
  endtask

  initial begin
    reset              = 1'b1;
    bus.in_valid       = 1'b0;
    bus.in_addr        = 32'd0;
    bus.in_wdata       = 32'd0;
    bus.in_wen         = 1'b0;
    bus.in_size        = 2'd0;
    bus.in_unsigned    = 1'b0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_rdata = 32'd0;
    bus.out_ready      = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_vals("por");
    reset = 1'b0;
    @(negedge clock);

    run_op(32'h8000_0004, 32'h0, 1'b0, 2'd2, 1'b0, 32'hDEAD_BEEF, 0, 0, 0);
    run_op(32'h8000_0001, 32'h0, 1'b0, 2'd0, 1'b0, 32'h8000_F080, 0, 0, 0);
    run_op(32'h8000_0001, 32'h0, 1'b0, 2'd0, 1'b1, 32'h8000_F080, 0, 0, 0);
    run_op(32'h8000_0003, 32'h0, 1'b0, 2'd0, 1'b0, 32'h8000_F080, 0, 0, 0);
    run_op(32'h8000_0102, 32'h1234_ABCD, 1'b1, 2'd1, 1'b0, 32'h5555_5555, 0, 0, 0);
    run_op(32'h8000_0002, 32'h0, 1'b0, 2'd2, 1'b0, 32'h0, 0, 0, 1);
    run_op(32'h8000_0001, 32'h0, 1'b0, 2'd1, 1'b0, 32'h0, 0, 0, 0);
    run_op(32'h8000_0042, 32'h0, 1'b0, 2'd1, 1'b0, 32'hC3A5_7F01, 3, 5, 2);

    // Abandon an op in WAIT, then offer a stale response
    bus.in_valid = 1'b1; bus.in_addr = 32'h8000_0010; bus.in_wen = 1'b0;
    bus.in_size = 2'd2; bus.in_unsigned = 1'b0;
    @(negedge clock);
    bus.in_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    @(negedge clock);
    bus.mem_req_ready = 1'b0;
    check_eq("rst_pre_resp_ready", {31'd0, bus.mem_resp_ready}, 32'd1);
    reset = 1'b1;
    @(negedge clock);
    check_reset_vals("mid");
    reset = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = 32'h1111_2222;
    @(negedge clock);
    bus.mem_resp_valid = 1'b0;
    check_reset_vals("late");
    run_op(32'h8000_0020, 32'h0, 1'b0, 2'd2, 1'b0, 32'h0BAD_F00D, 0, 1, 0);

    for (int k = 0; k < 300; k++) begin
      run_op($urandom, $urandom, 1'($urandom), 2'($urandom), 1'($urandom), $urandom,
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Multi-cycle load/store unit placed directly downstream of the execute stage.
- Consumes the ALU result as the effective address and rs2 as store data.
- Performs one memory transaction over a valid/ready request/response bus, then returns aligned, extended load data or store completion to writeback.
- Misaligned accesses are reported as errors; no memory traffic is generated for them.

Parameters:
- DWIDTH, 32, data/bus width; only 32 is supported.
- AWIDTH, 32, address width.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  execute stage presents a memory op
- in_ready  out  1  LSU can accept an op (high only in IDLE)
- in_addr  in  AWIDTH  effective address (ALU output)
- in_wdata  in  DWIDTH  store data (rs2)
- in_wen  in  1  1 = store, 0 = load
- in_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal and treated as misaligned
- in_unsigned  in  1  zero-extend load (LBU/LHU)
- mem_req_valid  out  1  request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  AWIDTH  word-aligned address, i.e. {addr[AWIDTH-1:2], 2'b00}
- mem_req_wen  out  1  write request
- mem_req_wdata  out  DWIDTH  store data shifted to its byte lane
- mem_req_wstrb  out  4  byte enables
- mem_resp_valid  in  1  response valid
- mem_resp_ready  out  1  LSU accepts response (high only in WAIT)
- mem_resp_rdata  in  DWIDTH  raw word read
- out_valid  out  1  result ready for writeback
- out_ready  in  1  writeback accepts result
- out_rdata  out  DWIDTH  extended load data; 0 for stores
- out_err  out  1  misaligned or illegal access

Behaviour:
- Reset state: IDLE.
  - Reset values: in_ready = 1; mem_req_valid, mem_req_wen, mem_resp_ready, out_valid, out_err = 0; mem_req_addr, mem_req_wdata, mem_req_wstrb, out_rdata = 0.
  - Reset mid-transaction abandons the op: no response is waited for, and a late mem_resp_valid after reset is ignored.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: on in_valid && in_ready, latch addr, wdata, wen, size and unsigned.
  - Misaligned (half with addr[0] = 1, word with addr[1:0] != 0, or size = 3): set out_err = 1 and go to DONE. No request is issued.
  - Otherwise go to REQ.
- REQ: mem_req_valid = 1; all request fields come from latched state and are stable while waiting.
  - On mem_req_ready, go to WAIT.
  - mem_req_valid must not drop before ready.
- WAIT: mem_resp_ready = 1. On mem_resp_valid, go to DONE.
  - For loads, register out_rdata = extract(rdata >> 8*addr[1:0], size), sign-extended unless unsigned.
  - For stores, rdata is ignored and out_rdata = 0.
- DONE: out_valid = 1; out_rdata and out_err hold until out_ready. On out_ready, go to IDLE and clear out_err.
- Minimum latency with a zero-wait memory:
  - accept in cycle N, request in N+1, response accepted in N+2, out_valid in N+3.
  - Misaligned op: out_valid in N+1.
- Only one op is in flight. in_ready is low in every state except IDLE, so back-to-back ops are spaced at least 4 cycles apart.
- Write strobes:
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << addr[1:0]
  - word: 4'b1111
- Write data: byte replicated to all 4 lanes, half replicated to both halves, word unchanged. Only strobed lanes are meaningful.
- Address arithmetic never wraps. The address is passed through with its low 2 bits zeroed.
- mem_req_ready asserted outside REQ and mem_resp_valid asserted outside WAIT are ignored.

Test Plan:
- Load word: addr = 0x80000004, memory returns 0xDEADBEEF with 0 wait -> mem_req_addr = 0x80000004, wstrb = 0, out_rdata = 0xDEADBEEF, out_valid 3 cycles after accept.
- Signed/unsigned byte: rdata = 0x8000F080, addr[1:0] = 1 -> LB gives 0xFFFFFFF0, LBU gives 0x000000F0; addr[1:0] = 3 with LB gives 0xFFFFFF80.
- Store half: addr = 0x80000102, wdata = 0x1234ABCD -> mem_req_addr = 0x80000100, wstrb = 4'b1100, wdata lanes[31:16] = 0xABCD, out_rdata = 0, out_err = 0.
- Misaligned: LW at 0x80000002 and LH at 0x80000001 -> no mem_req_valid ever, out_valid next cycle with out_err = 1.
- Backpressure: mem_req_ready low for 3 cycles, mem_resp_valid delayed 5 cycles, out_ready low for 2 cycles -> request fields stable, out_valid/out_rdata held, in_ready low throughout.
- Reset while in WAIT, then a late mem_resp_valid -> all outputs at reset values, state IDLE, late response ignored, next load completes normally.
